// File: rtl/tone_sequencer.sv
// Melody controller: walks a 16-entry note ROM and feeds divider/enable to the PWM tone generator.
// Optional key override (pause and play keys live) when TONE_SEQ_KEY_OVERRIDE_EN is defined.
module tone_sequencer #(
   parameter int BEAT_CYCLES = 12_500_000,
   parameter int GAP_CYCLES  = 1_250_000
) (
   input  logic        sys_clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        stop,
   input  logic        loop_en,
`ifdef TONE_SEQ_KEY_OVERRIDE_EN
   input  logic [3:0]  key,
`endif
   output logic [17:0] note_div,
   output logic        beep_en,
   output logic        busy,
   output logic [3:0]  note_idx,
   output logic        done
);

   localparam int NOTE_MAX = 4 * BEAT_CYCLES;
   localparam int MAX_CNT  = (NOTE_MAX > GAP_CYCLES) ? NOTE_MAX : GAP_CYCLES;
   localparam int CNT_W    = $clog2(MAX_CNT + 1);
   localparam logic [CNT_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

   typedef enum logic [1:0] {S_IDLE, S_NOTE, S_GAP} state_t;

   state_t            state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic [3:0]        idx_reg, idx_next;
   logic [17:0]       div_reg, div_next;
   logic              beep_reg, beep_next;
   logic              busy_reg, busy_next;
   logic              done_reg, done_next;
   logic              pause;
   logic              key_active;
   logic [17:0]       key_div;

   function automatic logic [2:0] rom_pitch(input logic [3:0] idx);
      case (idx)
         4'd0:  return 3'd1;
         4'd1:  return 3'd2;
         4'd2:  return 3'd3;
         4'd3:  return 3'd4;
         4'd4:  return 3'd5;
         4'd5:  return 3'd6;
         4'd6:  return 3'd7;
         4'd7:  return 3'd0;
         4'd8:  return 3'd7;
         4'd9:  return 3'd6;
         4'd10: return 3'd5;
         4'd11: return 3'd4;
         4'd12: return 3'd3;
         4'd13: return 3'd2;
         default: return 3'd1;
      endcase
   endfunction

   function automatic logic [1:0] rom_dur(input logic [3:0] idx);
      return (idx == 4'd15) ? 2'b00 : 2'b01;
   endfunction

   function automatic logic [17:0] pitch_div(input logic [2:0] pitch);
      case (pitch)
         3'd1:    return 18'd190_839;
         3'd2:    return 18'd170_067;
         3'd3:    return 18'd151_514;
         3'd4:    return 18'd143_265;
         3'd5:    return 18'd127_550;
         3'd6:    return 18'd113_635;
         3'd7:    return 18'd101_214;
         default: return 18'd0;
      endcase
   endfunction

   // Last count value of a note; duration code 00 encodes the longest (4-beat) note.
   function automatic logic [CNT_W-1:0] note_last(input logic [1:0] dur);
      int beats;
      beats = (dur == 2'b00) ? 4 : int'(dur);
      return CNT_W'(beats * BEAT_CYCLES - 1);
   endfunction

`ifdef TONE_SEQ_KEY_OVERRIDE_EN
   always_comb begin
      key_div = 18'd0;
      case (key)
         4'b0111: key_div = pitch_div(3'd1);
         4'b1011: key_div = pitch_div(3'd2);
         4'b1101: key_div = pitch_div(3'd3);
         4'b1110: key_div = pitch_div(3'd4);
         4'b0011: key_div = pitch_div(3'd5);
         4'b0101: key_div = pitch_div(3'd6);
         4'b0110: key_div = pitch_div(3'd7);
         default: key_div = 18'd0;
      endcase
   end
   assign key_active = (key != 4'b1111);
`else
   assign key_div    = 18'd0;
   assign key_active = 1'b0;
`endif

   assign pause = key_active && (state_reg != S_IDLE);

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      idx_next   = idx_reg;
      done_next  = 1'b0;
      div_next   = 18'd0;
      beep_next  = 1'b0;
      busy_next  = 1'b0;

      if (stop) begin
         state_next = S_IDLE;
         cnt_next   = '0;
         idx_next   = 4'd0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (start) begin
                  state_next = S_NOTE;
                  cnt_next   = '0;
                  idx_next   = 4'd0;
               end
            end
            S_NOTE, S_GAP: begin
               if (!pause) begin
                  if (state_reg == S_NOTE && cnt_reg != note_last(rom_dur(idx_reg))) begin
                     cnt_next = cnt_reg + 1'b1;
                  end else if (state_reg == S_NOTE && GAP_CYCLES > 0) begin
                     state_next = S_GAP;
                     cnt_next   = '0;
                  end else if (state_reg == S_GAP && cnt_reg != GAP_LAST) begin
                     cnt_next = cnt_reg + 1'b1;
                  end else begin
                     // End of the note's slot: advance, wrap, or finish the song.
                     cnt_next = '0;
                     if (idx_reg != 4'd15) begin
                        state_next = S_NOTE;
                        idx_next   = idx_reg + 4'd1;
                     end else if (loop_en) begin
                        state_next = S_NOTE;
                        idx_next   = 4'd0;
                     end else begin
                        state_next = S_IDLE;
                        idx_next   = 4'd0;
                        done_next  = 1'b1;
                     end
                  end
               end
            end
            default: begin
               state_next = S_IDLE;
               cnt_next   = '0;
               idx_next   = 4'd0;
            end
         endcase
      end

      busy_next = (state_next != S_IDLE);
      if (state_next == S_NOTE) begin
         div_next  = pitch_div(rom_pitch(idx_next));
         beep_next = (div_next != 18'd0);
      end
      if (key_active && !stop) begin
         div_next  = key_div;
         beep_next = (key_div != 18'd0);
      end
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_IDLE;
         cnt_reg   <= '0;
         idx_reg   <= 4'd0;
         div_reg   <= 18'd0;
         beep_reg  <= 1'b0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         idx_reg   <= idx_next;
         div_reg   <= div_next;
         beep_reg  <= beep_next;
         busy_reg  <= busy_next;
         done_reg  <= done_next;
      end
   end

   assign note_div = div_reg;
   assign beep_en  = beep_reg;
   assign busy     = busy_reg;
   assign note_idx = idx_reg;
   assign done     = done_reg;

endmodule

// File: tb/tb_tone_sequencer.sv
// Randomized directed bench for tone_sequencer against a per-cycle song model (BEAT=10, GAP=2).
// Define TONE_SEQ_KEY_OVERRIDE_EN to also exercise the key override.
module tb_tone_sequencer;

   localparam int BEAT = 10;
   localparam int GAP  = 2;
   localparam int SONG = 15 * (BEAT + GAP) + 4 * BEAT + GAP;

   typedef struct packed {
      logic [17:0] div;
      logic        beep;
      logic        busy;
      logic [3:0]  idx;
      logic        done;
   } exp_t;

   logic        sys_clk = 1'b0;
   logic        rst_n   = 1'b0;
   logic        start   = 1'b0;
   logic        stop    = 1'b0;
   logic        loop_en = 1'b0;
   logic [17:0] note_div;
   logic        beep_en;
   logic        busy;
   logic [3:0]  note_idx;
   logic        done;
`ifdef TONE_SEQ_KEY_OVERRIDE_EN
   logic [3:0]  key = 4'b1111;
`endif

   int errors = 0;
   int checks = 0;
   int div_tab [8] = '{0, 190839, 170067, 151514, 143265, 127550, 113635, 101214};

   tone_sequencer #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP)) dut (
      .sys_clk  (sys_clk),
      .rst_n    (rst_n),
      .start    (start),
      .stop     (stop),
      .loop_en  (loop_en),
`ifdef TONE_SEQ_KEY_OVERRIDE_EN
      .key      (key),
`endif
      .note_div (note_div),
      .beep_en  (beep_en),
      .busy     (busy),
      .note_idx (note_idx),
      .done     (done)
   );

   always #5 sys_clk = ~sys_clk;

   // Song as written in the note table: rising scale, a rest, falling scale, long final DO.
   function automatic int song_pitch(int n);
      if (n < 7) return n + 1;
      if (n == 7) return 0;
      if (n < 15) return 15 - n;
      return 1;
   endfunction

   function automatic int song_beats(int n);
      return (n == 15) ? 4 : 1;
   endfunction

   // Expected outputs t cycles after the start edge.
   function automatic exp_t model(int t_in, bit loop_on);
      exp_t e;
      int   t;
      int   acc;
      int   len;
      e   = '0;
      t   = loop_on ? (t_in % SONG) : t_in;
      if (t == SONG) e.done = 1'b1;
      if (t >= SONG) return e;
      acc = 0;
      for (int n = 0; n < 16; n++) begin
         len = song_beats(n) * BEAT;
         if (t < acc + len) begin
            e.busy = 1'b1;
            e.idx  = 4'(n);
            e.div  = 18'(div_tab[song_pitch(n)]);
            e.beep = (song_pitch(n) != 0);
            return e;
         end
         if (t < acc + len + GAP) begin
            e.busy = 1'b1;
            e.idx  = 4'(n);
            return e;
         end
         acc += len + GAP;
      end
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input exp_t e);
      chk({tag, ".note_div"}, 32'(note_div), 32'(e.div));
      chk({tag, ".beep_en"},  32'(beep_en),  32'(e.beep));
      chk({tag, ".busy"},     32'(busy),     32'(e.busy));
      chk({tag, ".note_idx"}, 32'(note_idx), 32'(e.idx));
      chk({tag, ".done"},     32'(done),     32'(e.done));
   endtask

   task automatic step();
      @(posedge sys_clk);
      @(negedge sys_clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      step();
      stop = 1'b0;
   endtask

   initial begin
      int sp;
      int st;
      int rt;
      int extra;
      int done_cnt;

      // Reset state
      repeat (2) @(negedge sys_clk);
      chk_all("reset_held", model(SONG + 1, 1'b0));
      rst_n = 1'b1;
      step();
      chk_all("idle_after_reset", model(SONG + 1, 1'b0));
      $display("txn reset: outputs idle after power-on reset");

      // Full song, no loop, with a start pulse during entry 2 that must be ignored
      loop_en  = 1'b0;
      sp       = int'($urandom_range(24, 35));
      done_cnt = 0;
      pulse_start();
      for (int t = 0; t <= SONG + 3; t++) begin
         chk_all("song", model(t, 1'b0));
         if (done === 1'b1) done_cnt++;
         start = (t == sp);
         step();
         start = 1'b0;
      end
      chk("done_pulse_count", 32'(done_cnt), 32'd1);
      $display("txn song: full play, ignored start at t=%0d, done pulses=%0d", sp, done_cnt);

      // Looping playback, then stop
      loop_en = 1'b1;
      extra   = int'($urandom_range(12, 60));
      pulse_start();
      for (int t = 0; t <= SONG + extra; t++) begin
         chk_all("loop", model(t, 1'b1));
         step();
      end
      pulse_stop();
      chk_all("loop_stop", model(SONG + 1, 1'b0));
      $display("txn loop: wrapped to entry 0, ran %0d cycles past the song end", extra);

      // Stop during entry 3
      loop_en = 1'b0;
      st      = int'($urandom_range(36, 47));
      pulse_start();
      for (int t = 0; t <= st; t++) begin
         chk_all("pre_stop", model(t, 1'b0));
         if (t != st) step();
      end
      pulse_stop();
      chk_all("stop_entry3", model(SONG + 1, 1'b0));
      step();
      chk_all("stop_idle_hold", model(SONG + 1, 1'b0));
      start = 1'b1;
      stop  = 1'b1;
      step();
      start = 1'b0;
      stop  = 1'b0;
      chk_all("stop_beats_start", model(SONG + 1, 1'b0));
      $display("txn stop: aborted at t=%0d, simultaneous start/stop stays idle", st);

      // Asynchronous reset during entry 5
      rt = int'($urandom_range(60, 69));
      pulse_start();
      for (int t = 0; t <= rt; t++) begin
         chk_all("pre_reset", model(t, 1'b0));
         if (t != rt) step();
      end
      #2 rst_n = 1'b0;
      #1;
      chk_all("async_reset", model(SONG + 1, 1'b0));
      @(negedge sys_clk);
      rst_n = 1'b1;
      step();
      chk_all("reset_release", model(SONG + 1, 1'b0));
      pulse_start();
      chk_all("restart_after_reset", model(0, 1'b0));
      pulse_stop();
      $display("txn reset: asserted at t=%0d mid entry 5, restart ok", rt);

`ifdef TONE_SEQ_KEY_OVERRIDE_EN
      // Key LA held mid entry 1, then RE resumes with its remaining count
      pulse_start();
      for (int t = 0; t <= 15; t++) begin
         chk_all("pre_key", model(t, 1'b0));
         if (t != 15) step();
      end
      key = 4'b0101;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("key.note_div", 32'(note_div), 32'd113635);
         chk("key.beep_en",  32'(beep_en),  32'd1);
         chk("key.note_idx", 32'(note_idx), 32'd1);
         chk("key.busy",     32'(busy),     32'd1);
      end
      key = 4'b1111;
      step();
      for (int t = 16; t <= 40; t++) begin
         chk_all("post_key", model(t, 1'b0));
         step();
      end
      pulse_stop();
      $display("txn key: LA override for 5 cycles in entry 1, RE resumed");
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
